// File: rtl/rsa_mont_mul_pipe.sv
// Bit-serial Montgomery multiplier: o_result = a*b*2^(-WIDTH) mod N, one multiplier bit per cycle.
// Valid/ready on both sides; o_error flags an even modulus captured at acceptance.
module rsa_mont_mul_pipe #(
  parameter int WIDTH = 256,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_modulus,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] nReg;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] stepped;
  logic [WIDTH+1:0] reduced;
  logic [CNT_W-1:0] counter;
  logic             errReg;

  // One radix-2 Montgomery iteration; two guard bits keep R + b + N from overflowing.
  function automatic logic [WIDTH+1:0] montStep(input logic [WIDTH+1:0] r,
                                                input logic             aBit,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] t;
    t = r + (aBit ? {2'b00, b} : '0);
    if (t[0]) t = t + {2'b00, n};
    return t >> 1;
  endfunction

  function automatic logic [WIDTH+1:0] finalReduce(input logic [WIDTH+1:0] r,
                                                   input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] d;
    if (r >= {2'b00, n}) d = r - {2'b00, n};
    else                 d = r;
    return d;
  endfunction

  assign stepped = montStep(acc, aReg[counter], bReg, nReg);
  assign reduced = finalReduce(acc, nReg);

  // Handshake outputs come straight from registered state, so no input-to-output path exists.
  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (state == IDLE && i_valid) begin
      aReg <= i_a;
      bReg <= i_b;
      nReg <= i_modulus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      acc      <= '0;
      errReg   <= 1'b0;
      o_result <= '0;
      o_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            acc     <= '0;
            counter <= '0;
            errReg  <= ~i_modulus[0];
            state   <= CALC;
          end
        end
        CALC: begin
          acc     <= stepped;
          counter <= counter + 1'b1;
          if (counter == CNT_W'(WIDTH - 1)) state <= FINAL;
        end
        FINAL: begin
          acc      <= reduced;
          o_result <= reduced[WIDTH-1:0];
          o_error  <= errReg;
          state    <= DONE;
        end
        DONE: begin
          if (o_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rsa_mont_mul_pipe.md
Name: rsa_mont_mul_pipe

Overview:
- Parametrised, bit-serial Montgomery modular multiplier with valid/ready handshakes on input and output.
- Computes a·b·2^(-WIDTH) mod modulus.
- Generalised successor of the fixed 256-bit RSAMontgomeryMod datapath: key width is a parameter, and it adds back-pressure plus a precondition-error flag.
- Sits under the modular-exponentiation controller, which issues square and multiply operations through it.

Parameters:
- WIDTH, 256, operand/modulus width in bits (≥ 4).
- CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  input operands valid.
- i_ready  out  1  block can accept operands.
- i_a  in  WIDTH  multiplicand a.
- i_b  in  WIDTH  multiplier b.
- i_modulus  in  WIDTH  modulus N.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_result  out  WIDTH  a·b·2^(-WIDTH) mod N.
- o_error  out  1  qualified by o_valid; 1 if N was even when accepted.

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on rising edge.
- Reset: state IDLE, i_ready=1, o_valid=0, o_result=0, o_error=0, counter=0, accumulator=0. Reset mid-operation aborts the job; no output is produced for it.
- States: IDLE → CALC → FINAL → DONE → IDLE.
- IDLE: i_ready=1.
  - On i_valid&i_ready, latch a, b, N; clear accumulator R (WIDTH+2 bits); counter=0; latch err = ~N[0]; go to CALC.
- CALC: i_ready=0. Each cycle, for bit i = counter (LSB first):
  - t = R + (a[i] ? b : 0);
  - if t[0], t = t + N;
  - R = t >> 1.
  - Counter increments. After the iteration with counter == WIDTH-1, go to FINAL. Exactly WIDTH CALC cycles.
- FINAL: if R ≥ N, R = R − N. Load o_result = R[WIDTH-1:0] and o_error = err. Go to DONE.
- DONE: o_valid=1; o_result and o_error held stable while o_ready=0 (indefinite stall allowed).
  - On o_valid&o_ready, go to IDLE, o_valid=0. o_result keeps its last value.
- Latency: acceptance edge at cycle 0; o_valid high from cycle WIDTH+2. Minimum issue interval is WIDTH+3 cycles (DONE handshake and next acceptance cannot share a cycle).
- Width rules:
  - Precondition a, b < N, N odd. Then R < 2N holds throughout and WIDTH+2 bits never overflow.
  - Inputs violating a, b < N produce an unspecified result but the same timing, with no hang.
  - Even N: the computation runs normally but o_error=1 and o_result is don't-care.
- Input changes while i_ready=0 are ignored. i_valid may be held high across a busy period; the next acceptance occurs in IDLE.
- No combinational path from i_valid to i_ready or from o_ready to o_valid.

Test Plan:
- WIDTH=8, a=5, b=7, N=13 → o_result=1, o_error=0, o_valid asserted exactly 10 cycles after acceptance.
- WIDTH=8, a=1, b=1, N=13 → 3. Then a=b=12, N=13 → 3. Then a=0, b=9, N=13 → 0. Issued back-to-back with i_valid held high, o_ready=1; accepts spaced exactly 11 cycles.
- WIDTH=8, a=5, b=7, N=13, o_ready held 0 for 20 cycles → o_valid stays 1, o_result stays 1, i_ready stays 0; release → one handshake, i_ready=1 next cycle.
- WIDTH=8, N=12 (even), a=5, b=7 → o_valid with o_error=1 after 10 cycles; block returns to IDLE normally.
- Assert rst for one cycle during CALC (cycle 4) → next cycle i_ready=1, o_valid=0, o_result=0; the following job a=5, b=7, N=13 returns 1.
- WIDTH=256, 1000 random odd N with MSB set and random a, b < N → o_result matches a·b·2^(-256) mod N from the C++ golden model; latency 258 cycles each.
